gate_sweep_checker: RTL
=======================

# gate_sweep_checker

Self-checking stimulus/response stage wrapped around the two-input basic-gate block. Drives its `a`/`b` inputs through all four input combinations and waits a programmable settle time per vector. Samples the seven gate outputs, compares them against golden values, and reports a per-run pass flag, a failing-vector count and a sticky per-gate error mask. It is the upstream driver and downstream consumer of the gate block, used for on-chip or FPGA self-test.

## Interface
Parameters:
- `SETTLE`, default 2: cycles to wait after `a`/`b` change before sampling; legal range 1..255.
- `ERR_W`, default 4: width of `err_cnt`; minimum 3.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a sweep; sampled only in IDLE.
- `a` out 1: gate input A, registered.
- `b` out 1: gate input B, registered.
- `y_and`, `y_or`, `y_nand`, `y_nor`, `y_xor`, `y_xnor`, `y_not` in 1 each: gate outputs under test.
- `busy` out 1: high while a sweep is in WAIT/CHECK.
- `done` out 1: one-cycle pulse at end of sweep.
- `pass` out 1: result of last completed sweep; held until the next start.
- `err_cnt` out ERR_W: number of failing vectors in the current/last sweep.
- `err_mask` out 7: sticky OR of mismatching gates. Bit order: [6]and [5]or [4]nand [3]nor [2]xor [1]xnor [0]not.

## Operation
- Golden values for vector `{a,b}`: and=a&b, or=a|b, nand=~(a&b), nor=~(a|b), xor=a^b, xnor=~(a^b), not=~a.
- Vector index `v` (2 bits) drives `{a,b}=v`. Order: 00, 01, 10, 11.
- FSM states: IDLE, WAIT, CHECK, FINISH.
- IDLE: `a=b=0`. On `start=1`: `v<=0`, `{a,b}<=00`, `wcnt<=SETTLE-1`, `err_cnt<=0`, `err_mask<=0`, `pass<=0`, go to WAIT.
- WAIT: if `wcnt==0`, go to CHECK; else decrement `wcnt`.
- CHECK: form a 7-bit mismatch vector of the sampled inputs versus golden for the current `{a,b}`.
  - If the mismatch vector is nonzero: `err_cnt` += 1, saturating at all-ones; `err_mask |=` mismatch.
  - If `v==3`: go to FINISH.
  - Otherwise: `v<=v+1`, `{a,b}<=v+1`, reload `wcnt`, go to WAIT.
- FINISH: `done=1` for exactly this cycle; `pass<=(err_cnt==0)`, where `err_cnt` is the final value including the last CHECK. Go to IDLE.
- `start` is ignored in WAIT, CHECK and FINISH. Results are not disturbed.
- Error count is per failing vector, not per failing bit. Maximum value is 4.

## Timing
- Reset values: `a=0`, `b=0`, `busy=0`, `done=0`, `pass=0`, `err_cnt=0`, `err_mask=0`, state IDLE.
- Let E0 be the edge that samples `start`.
  - `{a,b}=00` and `busy=1` from E0.
  - Each vector occupies SETTLE+1 cycles (SETTLE in WAIT, 1 in CHECK).
  - FINISH is entered at E0+4·(SETTLE+1): `done=1` and `busy=0` in that cycle. `pass` becomes valid at the next edge.
  - For SETTLE=2: vector changes at E3, E6, E9; `done` asserts after E12.
- `start` held high continuously gives back-to-back sweeps with period 4·(SETTLE+1)+2 cycles (FINISH, then one IDLE cycle).
- `rst` asserted in any state: at the next edge every output takes its reset value and the state is IDLE. No `done` pulse is produced for the aborted sweep.
- `rst` and `start` high on the same edge: reset wins.
- Gate outputs are sampled combinationally in CHECK. The gate block must settle within SETTLE cycles of `a`/`b` changing.

## Test plan
- Correct gate block, SETTLE=2, `start` pulse → `a,b` sequence 00,01,10,11 at E0/E3/E6/E9; `done` after E12; then `pass=1`, `err_cnt=0`, `err_mask=0000000`.
- `y_xor` forced to 0 → failing vectors 01 and 10; `err_cnt=2`, `err_mask=0000100`, `pass=0`.
- `y_not` wired to `~b` → failing vectors 01 and 10; `err_cnt=2`, `err_mask=0000001`, `pass=0`. A following sweep with a correct block gives `pass=1` and cleared mask.
- `rst` pulsed while `{a,b}=10` → next edge: all outputs zero, `busy=0`, no `done`. A new `start` then gives a full clean sweep.
- `start` held high, SETTLE=2 → `done` pulses every 14 cycles. Extra `start` pulses while `busy=1` change nothing.
- SETTLE=1 → vectors change every 2 cycles; `done` after E8.

Source files
------------

// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker: drives a two-input gate block through all four input
// vectors, waits a settle time per vector, checks the seven gate outputs
// against golden values and reports pass, failing-vector count and error mask.
module gate_sweep_checker #(
  parameter int unsigned SETTLE = 2,
  parameter int unsigned ERR_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a,
  output logic             b,
  input  logic             y_and,
  input  logic             y_or,
  input  logic             y_nand,
  input  logic             y_nor,
  input  logic             y_xor,
  input  logic             y_xnor,
  input  logic             y_not,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [6:0]       err_mask
);

  localparam int unsigned WCNT_W = 8;
  localparam logic [WCNT_W-1:0] WCNT_RELOAD = WCNT_W'(SETTLE - 1);
  localparam logic [ERR_W-1:0]  ERR_MAX     = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_CHECK,
    ST_FINISH
  } state_t;

  state_t            state_q;
  logic [1:0]        v_q;
  logic [WCNT_W-1:0] wcnt_q;
  logic              a_q;
  logic              b_q;
  logic              busy_q;
  logic              done_q;
  logic              pass_q;
  logic [ERR_W-1:0]  err_cnt_q;
  logic [6:0]        err_mask_q;

  logic [6:0]        golden_c;
  logic [6:0]        sampled_c;
  logic [6:0]        mismatch_c;
  logic [ERR_W-1:0]  err_cnt_d;
  logic [1:0]        v_d;

  // Golden response for the vector currently driven, and the mismatch against the block
  always_comb begin
    golden_c   = {a_q & b_q, a_q | b_q, ~(a_q & b_q), ~(a_q | b_q),
                  a_q ^ b_q, ~(a_q ^ b_q), ~a_q};
    sampled_c  = {y_and, y_or, y_nand, y_nor, y_xor, y_xnor, y_not};
    mismatch_c = golden_c ^ sampled_c;
  end

  // Saturating failing-vector count and next vector index
  always_comb begin
    err_cnt_d = (err_cnt_q == ERR_MAX) ? err_cnt_q : err_cnt_q + ERR_W'(1);
    v_d       = v_q + 2'd1;
  end

  // Sweep sequencer: one vector per WAIT/CHECK pair, results latched in FINISH
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      v_q        <= 2'd0;
      wcnt_q     <= '0;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_cnt_q  <= '0;
      err_mask_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            v_q        <= 2'd0;
            a_q        <= 1'b0;
            b_q        <= 1'b0;
            wcnt_q     <= WCNT_RELOAD;
            err_cnt_q  <= '0;
            err_mask_q <= '0;
            pass_q     <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (wcnt_q == '0) begin
            state_q <= ST_CHECK;
          end else begin
            wcnt_q <= wcnt_q - WCNT_W'(1);
          end
        end
        ST_CHECK: begin
          if (mismatch_c != 7'd0) begin
            err_cnt_q  <= err_cnt_d;
            err_mask_q <= err_mask_q | mismatch_c;
          end
          if (v_q == 2'd3) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_FINISH;
          end else begin
            v_q     <= v_d;
            a_q     <= v_d[1];
            b_q     <= v_d[0];
            wcnt_q  <= WCNT_RELOAD;
            state_q <= ST_WAIT;
          end
        end
        ST_FINISH: begin
          // err_cnt_q already includes the last CHECK
          pass_q  <= (err_cnt_q == '0);
          a_q     <= 1'b0;
          b_q     <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign a        = a_q;
  assign b        = b_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign err_cnt  = err_cnt_q;
  assign err_mask = err_mask_q;

endmodule
